// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate-format selects, base opcodes,
// and the decode stage's occupancy state type.
package riscv_pkg;

    // Immediate format selects shared with the immediate generator
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // RV32I base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational opcode decoder: picks the immediate format and flags
// opcodes outside the supported RV32I set.
module inst_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       illegal
);

    // Opcode to immediate-format lookup; unknown opcodes are illegal
    always_comb begin
        imm_sel = IMM_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: imm_sel = IMM_I;
            OPC_STORE:                                  imm_sel = IMM_S;
            OPC_BRANCH:                                 imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:                         imm_sel = IMM_U;
            OPC_JAL:                                    imm_sel = IMM_J;
            OPC_OP:                                     imm_sel = IMM_NONE;
            default:                                    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: two-entry skid buffer (main + skid) between fetch and
// execute. Opcode is decoded on entry so every output comes from flops.
// When the stage empties, main is reloaded with the NOP image so the
// outputs stay registered without an output mux.
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [2:0]  out_imm_sel,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_illegal
);

    stage_state_t state_reg, state_next;
    logic         in_ready_reg;

    logic [31:0] main_inst_reg, main_inst_next;
    logic [31:0] main_pc_reg,   main_pc_next;
    logic [2:0]  main_sel_reg,  main_sel_next;
    logic        main_ill_reg,  main_ill_next;

    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] skid_pc_reg,   skid_pc_next;
    logic [2:0]  skid_sel_reg,  skid_sel_next;
    logic        skid_ill_reg,  skid_ill_next;

    logic [2:0] dec_sel;
    logic       dec_ill;
    logic       in_xfer;
    logic       out_xfer;

    inst_decoder u_inst_decoder (
        .opcode  (in_inst[6:0]),
        .imm_sel (dec_sel),
        .illegal (dec_ill)
    );

    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = (state_reg != ST_EMPTY) & out_ready;

    // Next state and entry contents; flush overrides every other move
    always_comb begin
        state_next     = state_reg;
        main_inst_next = main_inst_reg;
        main_pc_next   = main_pc_reg;
        main_sel_next  = main_sel_reg;
        main_ill_next  = main_ill_reg;
        skid_inst_next = skid_inst_reg;
        skid_pc_next   = skid_pc_reg;
        skid_sel_next  = skid_sel_reg;
        skid_ill_next  = skid_ill_reg;

        if (flush) begin
            state_next     = ST_EMPTY;
            main_inst_next = NOP_INST;
            main_pc_next   = 32'd0;
            main_sel_next  = IMM_I;
            main_ill_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_next     = ST_ONE;
                        main_inst_next = in_inst;
                        main_pc_next   = in_pc;
                        main_sel_next  = dec_sel;
                        main_ill_next  = dec_ill;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_inst_next = in_inst;
                        main_pc_next   = in_pc;
                        main_sel_next  = dec_sel;
                        main_ill_next  = dec_ill;
                    end else if (in_xfer) begin
                        state_next     = ST_FULL;
                        skid_inst_next = in_inst;
                        skid_pc_next   = in_pc;
                        skid_sel_next  = dec_sel;
                        skid_ill_next  = dec_ill;
                    end else if (out_xfer) begin
                        state_next     = ST_EMPTY;
                        main_inst_next = NOP_INST;
                        main_pc_next   = 32'd0;
                        main_sel_next  = IMM_I;
                        main_ill_next  = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_next     = ST_ONE;
                        main_inst_next = skid_inst_reg;
                        main_pc_next   = skid_pc_reg;
                        main_sel_next  = skid_sel_reg;
                        main_ill_next  = skid_ill_reg;
                    end
                end
                default: begin
                    state_next     = ST_EMPTY;
                    main_inst_next = NOP_INST;
                    main_pc_next   = 32'd0;
                    main_sel_next  = IMM_I;
                    main_ill_next  = 1'b0;
                end
            endcase
        end
    end

    // State, entries and the look-ahead in_ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b0;
            main_inst_reg <= NOP_INST;
            main_pc_reg   <= 32'd0;
            main_sel_reg  <= IMM_I;
            main_ill_reg  <= 1'b0;
            skid_inst_reg <= 32'd0;
            skid_pc_reg   <= 32'd0;
            skid_sel_reg  <= IMM_NONE;
            skid_ill_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_FULL);
            main_inst_reg <= main_inst_next;
            main_pc_reg   <= main_pc_next;
            main_sel_reg  <= main_sel_next;
            main_ill_reg  <= main_ill_next;
            skid_inst_reg <= skid_inst_next;
            skid_pc_reg   <= skid_pc_next;
            skid_sel_reg  <= skid_sel_next;
            skid_ill_reg  <= skid_ill_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = (state_reg != ST_EMPTY);
    assign out_inst    = main_inst_reg;
    assign out_pc      = main_pc_reg;
    assign out_imm_sel = main_sel_reg;
    assign out_illegal = main_ill_reg;
    assign out_rd      = main_inst_reg[11:7];
    assign out_rs1     = main_inst_reg[19:15];
    assign out_rs2     = main_inst_reg[24:20];

endmodule
